// File: rtl/nexys_starship_pkg.sv
// nexys_starship_pkg: shared global/lane state encodings and default timeout
package nexys_starship_pkg;
  typedef enum logic [2:0] {G_INIT = 3'b001, G_PLAY = 3'b010, G_OVER = 3'b100} game_t;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} lane_t;
  localparam int DEF_TIMEOUT = 6;
endpackage

// File: rtl/nexys_starship_lane.sv
// nexys_starship_lane: one monster lane (EMPTY/FULL FSM plus saturating stay timer)
// Ports: timer_clk/Reset (async, active-high); run (global PLAY), freeze (hold this cycle),
// clear (force EMPTY, timer 0); spawn/kill requests; full, expire, kill_ok (kill accepted);
// warn (full and timer >= WARN_AT) exists only with NEXYS_STARSHIP_WARN_EN.
module nexys_starship_lane
  import nexys_starship_pkg::*;
#(
  parameter int TIMER_W = 8,
  parameter int TIMEOUT = DEF_TIMEOUT
`ifdef NEXYS_STARSHIP_WARN_EN
  , parameter int WARN_AT = 4
`endif
) (
  input  logic timer_clk,
  input  logic Reset,
  input  logic run,
  input  logic freeze,
  input  logic clear,
  input  logic spawn,
  input  logic kill,
  output logic full,
  output logic expire,
  output logic kill_ok
`ifdef NEXYS_STARSHIP_WARN_EN
  , output logic warn
`endif
);
  localparam logic [TIMER_W-1:0] TMAX = TIMER_W'(TIMEOUT);
  lane_t st, st_n;
  logic [TIMER_W-1:0] tm, tm_n;
  logic act;
  always_ff @(posedge timer_clk or posedge Reset)
    if (Reset) begin
      st <= EMPTY;
      tm <= '0;
    end else begin
      st <= st_n;
      tm <= tm_n;
    end
  always_comb begin
    act = run && !freeze;
    st_n = st;
    if (clear) st_n = EMPTY;
    else if (act && st == EMPTY && spawn) st_n = FULL;
    else if (act && st == FULL && kill) st_n = EMPTY;
    tm_n = (clear || (act && (st == EMPTY ? spawn : kill))) ? '0 :
           (act && st == FULL && tm != TMAX) ? tm + TIMER_W'(1) : tm;
  end
  assign full = st == FULL;
  assign expire = full && tm == TMAX;
  assign kill_ok = act && full && kill;
`ifdef NEXYS_STARSHIP_WARN_EN
  assign warn = full && tm >= TIMER_W'(WARN_AT);
`endif
endmodule

// File: rtl/nexys_starship_lanes.sv
// nexys_starship_lanes: multi-lane monster controller with global INIT/PLAY/OVER game FSM
// Ports: timer_clk/Reset (async, active-high); play_flag, gameover_clr; spawn_req/kill per lane;
// lane_full, gameover, over_lane (lowest expired lane), kill_count (saturating), q_Init/q_Play/q_Over.
// Optional NEXYS_STARSHIP_WARN_EN adds parameter WARN_AT and output lane_warn.
module nexys_starship_lanes
  import nexys_starship_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int TIMER_W = 8,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int KCNT_W = 8,
`ifdef NEXYS_STARSHIP_WARN_EN
  parameter int WARN_AT = 4,
`endif
  localparam int OL_W = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1
) (
  input  logic                 timer_clk,
  input  logic                 Reset,
  input  logic                 play_flag,
  input  logic                 gameover_clr,
  input  logic [NUM_LANES-1:0] spawn_req,
  input  logic [NUM_LANES-1:0] kill,
  output logic [NUM_LANES-1:0] lane_full,
`ifdef NEXYS_STARSHIP_WARN_EN
  output logic [NUM_LANES-1:0] lane_warn,
`endif
  output logic                 gameover,
  output logic [OL_W-1:0]      over_lane,
  output logic [KCNT_W-1:0]    kill_count,
  output logic                 q_Init,
  output logic                 q_Play,
  output logic                 q_Over
);
  localparam int SW = KCNT_W + $clog2(NUM_LANES + 1);
  localparam logic [KCNT_W-1:0] KMAX = '1;
  game_t st, st_n;
  logic [NUM_LANES-1:0] expire, kill_ok;
  logic any_exp;
  logic [OL_W-1:0] first;
  logic [SW-1:0] sum;
  logic [KCNT_W-1:0] kc_n;
`ifdef NEXYS_STARSHIP_WARN_EN
  logic [NUM_LANES-1:0] warn;
`endif
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    nexys_starship_lane #(
      .TIMER_W(TIMER_W),
      .TIMEOUT(TIMEOUT)
`ifdef NEXYS_STARSHIP_WARN_EN
      , .WARN_AT(WARN_AT)
`endif
    ) u_lane (
      .timer_clk(timer_clk),
      .Reset(Reset),
      .run(q_Play),
      .freeze(any_exp),
      .clear(q_Init),
      .spawn(spawn_req[i]),
      .kill(kill[i]),
      .full(lane_full[i]),
      .expire(expire[i]),
      .kill_ok(kill_ok[i])
`ifdef NEXYS_STARSHIP_WARN_EN
      , .warn(warn[i])
`endif
    );
  end
  always_ff @(posedge timer_clk or posedge Reset)
    if (Reset) begin
      st <= G_INIT;
      over_lane <= '0;
      kill_count <= '0;
    end else begin
      st <= st_n;
      if (q_Play && any_exp) over_lane <= first;
      kill_count <= q_Init ? '0 : kc_n;
    end
  // An expiry freezes every lane for the cycle, so no kill is counted alongside it.
  always_comb begin
    any_exp = |expire;
    first = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) if (expire[i]) first = OL_W'(i);
    sum = SW'(kill_count);
    for (int i = 0; i < NUM_LANES; i++) sum = sum + SW'(kill_ok[i]);
    kc_n = sum > SW'(KMAX) ? KMAX : sum[KCNT_W-1:0];
    st_n = st;
    case (st)
      G_INIT: st_n = play_flag ? G_PLAY : G_INIT;
      G_PLAY: st_n = any_exp ? G_OVER : G_PLAY;
      G_OVER: st_n = gameover_clr ? G_INIT : G_OVER;
      default: st_n = G_INIT;
    endcase
  end
  assign q_Init = st[0];
  assign q_Play = st[1];
  assign q_Over = st[2];
  assign gameover = q_Over;
`ifdef NEXYS_STARSHIP_WARN_EN
  assign lane_warn = warn & {NUM_LANES{~q_Init}};
`endif
endmodule

// File: doc/nexys_starship_lanes.md
# nexys_starship_lanes

Parametrised multi-lane monster controller for Nexys Starship. It generalises the single top-monster state machine to NUM_LANES independent lanes (top, bottom, left, right, ...), each with a spawn/kill state machine and a countdown timer. A global game FSM turns any lane timeout into a game-over event and reports which lane caused it. It also keeps a saturating kill counter for the score display.

## Interface
Parameters:
- NUM_LANES, 4, number of monster lanes (>=1)
- TIMER_W, 8, lane timer width
- TIMEOUT, 6, timer_clk cycles a monster may stay before game over (1 <= TIMEOUT < 2^TIMER_W)
- KCNT_W, 8, kill counter width
- WARN_AT, 4, warning threshold (present only with NEXYS_STARSHIP_WARN_EN; WARN_AT < TIMEOUT)

Ports:
- timer_clk  in  1  clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high
- play_flag  in  1  start request, sampled in INIT
- gameover_clr  in  1  acknowledge game over, sampled in OVER
- spawn_req  in  NUM_LANES  per-lane spawn request (random source)
- kill  in  NUM_LANES  per-lane player hit
- lane_full  out  NUM_LANES  monster present in lane
- lane_warn  out  NUM_LANES  lane timer >= WARN_AT (macro only)
- gameover  out  1  high while in OVER
- over_lane  out  max(1,$clog2(NUM_LANES))  lowest-index lane that expired
- kill_count  out  KCNT_W  saturating count of successful kills
- q_Init, q_Play, q_Over  out  1 each  one-hot global state

## Operation
- Global FSM INIT -> PLAY -> OVER -> INIT:
  - INIT: lanes forced EMPTY, timers 0, kill_count 0. play_flag=1 -> PLAY.
  - PLAY: lanes run. Any lane expired -> OVER, latch over_lane (lowest expired index). play_flag ignored.
  - OVER: lanes frozen (lane_full, timers held for display). gameover_clr=1 -> INIT.
- Lane FSM (PLAY only), states EMPTY/FULL:
  - EMPTY and spawn_req[i] -> FULL, timer 0. kill[i] ignored.
  - FULL and kill[i] -> EMPTY, timer 0, counted as a kill. spawn_req[i] ignored.
  - FULL, no kill -> timer increments and saturates at TIMEOUT.
  - expire[i] = FULL && timer == TIMEOUT (combinational).
- Kill vs expire in the same cycle: expire wins. Global goes OVER; kill not applied or counted.
- kill_count adds popcount of valid kills per cycle and saturates at 2^KCNT_W-1.
- Reset (any time, including mid-game): state INIT, lane_full 0, timers 0, gameover 0, over_lane 0, kill_count 0, lane_warn 0, q_Init=1.

## Timing
- spawn_req[i] sampled at edge E0 -> lane_full[i]=1 after E0, timer=0.
- Timer reaches TIMEOUT at edge E0+TIMEOUT. gameover=1 after edge E0+TIMEOUT+1 (7 edges with default).
- kill[i] sampled at any edge up to E0+TIMEOUT clears the lane; at E0+TIMEOUT+1 it is too late.
- play_flag at edge E -> q_Play after E. Spawns are accepted from edge E+1.
- gameover_clr at edge E -> q_Init after E. lane_full, kill_count and gameover are 0 after E+1 at latest.
- All outputs are registered, except lane_warn, which is decoded from registers.

## Configuration
- NEXYS_STARSHIP_WARN_EN defined: WARN_AT parameter and lane_warn port exist. lane_warn[i] = FULL && timer >= WARN_AT; it holds in OVER and is 0 in INIT.
- Not defined: lane_warn port and WARN_AT absent. All other behaviour is identical.

## Structure
- Shared package nexys_starship_pkg: global state encodings (INIT=3'b001, PLAY=3'b010, OVER=3'b100), lane state encodings (EMPTY, FULL), default TIMEOUT.
- Sub-module nexys_starship_lane: one lane FSM plus timer, with inputs run/freeze/clear from the global FSM and output expire. It is instantiated NUM_LANES times in a generate loop. The top level holds the global FSM, priority encoder, popcount and kill counter.

## Test plan
- Reset mid-PLAY with lanes 0 and 2 full -> q_Init=1, lane_full=0, kill_count=0 immediately (asynchronous).
- play_flag, spawn lane 1 at E0, no kill -> gameover=1 after E0+7, over_lane=1, lane_full=4'b0010 held.
- Spawn lane 0 at E0, kill[0] at E0+6 -> lane empties, kill_count=1, no game over. kill at E0+7 -> OVER, kill_count=0.
- Lanes 3 and 1 spawned on the same edge, never killed -> over_lane=1 (lowest index).
- kill=4'b1111 with all lanes full, KCNT_W=2, repeated -> kill_count goes 0, then 3, then stays 3 (saturation).
- With NEXYS_STARSHIP_WARN_EN, spawn lane 2 at E0 -> lane_warn[2] rises after E0+4; kill -> 0 the next cycle.
